// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a registered valid/ready output stage and word-address tagging.
// Optional: define ENCODER_ILLEGAL_TRAP_EN to drop illegal ops (6, 7) and raise a sticky err flag.
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [12:0]       req_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

  function automatic logic [31:0] encode(
    input logic [2:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [12:0] imm
  );
    logic [31:0] w;
    case (op)
      3'd0:    w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3'd1:    w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3'd2:    w = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
      3'd3:    w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      3'd4:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      3'd5:    w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  logic              vld_p1;
  logic [31:0]       instr_p0;
  logic [31:0]       instr_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [ADDR_W-1:0] next_addr;
  logic              accept;
  logic              load;

  assign req_ready = !reset && !flush && (!vld_p1 || out_ready);
  assign accept    = req_valid && req_ready;
  assign instr_p0  = encode(req_op, req_rd, req_rs1, req_rs2, req_imm);

`ifdef ENCODER_ILLEGAL_TRAP_EN
  logic illegal;
  logic err_q;

  assign illegal = req_op[2] && req_op[1];
  assign load    = accept && !illegal;
  assign err     = err_q;

  // err stays set until reset; flush deliberately leaves it alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= 1'b0;
    else if (accept && illegal)
      err_q <= 1'b1;
  end
`else
  assign load = accept;
  assign err  = 1'b0;
`endif

  // p0 -> p1: combinational encode captured into the output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      instr_p1  <= '0;
      addr_p1   <= '0;
      next_addr <= START;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      next_addr <= START;
    end else if (load) begin
      vld_p1    <= 1'b1;
      instr_p1  <= instr_p0;
      addr_p1   <= next_addr;
      next_addr <= next_addr + ADDR_W'(1);
    end else if (out_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_instr = instr_p1;
  assign out_addr  = addr_p1;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the width of the instruction-memory word address.
REQ-002 Parameter START_ADDR, default 0, SHALL set the first word address emitted after reset or flush.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 flush  input  1  SHALL be a synchronous restart of the address sequence.
REQ-006 req_valid  input  1  SHALL indicate that an encode request is present.
REQ-007 req_ready  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-008 req_op  input  3  SHALL select the instruction: 0 ADD, 1 SUB, 2 ADDI, 3 LW, 4 SW, 5 BEQ; 6 and 7 are illegal.
REQ-009 req_rd, req_rs1, req_rs2  input  5 each  SHALL carry the register indices.
REQ-010 req_imm  input  13  SHALL carry the immediate: bits [11:0] for I/S-type, bits [12:1] for B-type (bit 0 ignored).
REQ-011 out_valid  output  1  SHALL indicate that an encoded word is present.
REQ-012 out_ready  input  1  SHALL indicate that the consumer takes the word this cycle.
REQ-013 out_instr  output  32  SHALL carry the encoded RV32I instruction word.
REQ-014 out_addr  output  ADDR_W  SHALL carry the word address assigned to out_instr.
REQ-015 err  output  1  SHALL be a sticky illegal-request flag (REQ-031).

Function
REQ-016 A request SHALL be accepted when req_valid && req_ready; req_ready SHALL equal !flush && (!out_valid || out_ready).
REQ-017 Latency: out_instr, out_addr and out_valid SHALL be registered and presented exactly one cycle after acceptance (back-to-back throughput, one word per cycle).
REQ-018 out_valid, out_instr and out_addr SHALL hold stable while out_valid && !out_ready.
REQ-019 An output transfer and an acceptance in the same cycle SHALL replace the output register with the new word, with no bubble.
REQ-020 R-type (ADD, SUB): opcode 0110011, funct3 000, funct7 0000000 (ADD) or 0100000 (SUB); layout funct7|rs2|rs1|funct3|rd|opcode.
REQ-021 I-type: ADDI opcode 0010011, funct3 000; LW opcode 0000011, funct3 010; layout imm[11:0]|rs1|funct3|rd|opcode.
REQ-022 S-type SW: opcode 0100011, funct3 010; layout imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
REQ-023 B-type BEQ: opcode 1100011, funct3 000; layout imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
REQ-024 Fields unused by the selected format SHALL NOT affect out_instr.
REQ-025 An internal next-address counter SHALL be copied into out_addr on acceptance and then increment by 1.
REQ-026 The counter SHALL wrap from 2^ADDR_W-1 to 0 without any other effect.
REQ-027 flush SHALL clear out_valid, set the counter to START_ADDR and block acceptance that cycle; flush has priority over every other event and leaves err unchanged.

Reset
REQ-028 While reset is high: out_valid=0, out_instr=0, out_addr=0, err=0, counter=START_ADDR.
REQ-029 req_ready SHALL be 0 while reset is high, and follow REQ-016 from the first clock edge after deassertion.
REQ-030 Reset asserted mid-transfer SHALL discard the held word with no partial output.

Configuration
REQ-031 With ENCODER_ILLEGAL_TRAP_EN defined, an accepted request with req_op 6 or 7 SHALL be dropped (no output word, counter unchanged) and SHALL set err until reset.
REQ-032 Without ENCODER_ILLEGAL_TRAP_EN, req_op 6 or 7 SHALL be encoded as NOP 0x00000013 with a normal address, and err SHALL be constant 0.

Verification
REQ-033 After reset, accept ADD rd=3 rs1=1 rs2=2, then SUB with the same fields, with out_ready=1 -> 0x002081B3 at addr 0, then 0x402081B3 at addr 1, on consecutive cycles.
REQ-034 ADDI x1,x0,5 -> 0x00500093; LW x5,8(x2) -> 0x00812283; SW x5,12(x2) -> 0x00512623; BEQ x1,x2,imm=0x1FFC (-4) -> 0xFE208EE3.
REQ-035 Hold out_ready=0 for 3 cycles with out_valid=1 -> req_ready=0 and out_* stable; release -> the next request is accepted in the same cycle.
REQ-036 ADDR_W=2, 5 requests -> out_addr sequence 0,1,2,3,0.
REQ-037 Issue flush while out_valid=1, then one ADDI -> the held word is dropped and the ADDI emerges at out_addr=START_ADDR.
REQ-038 req_op=7: with the macro -> no output and err=1 until reset; without the macro -> 0x00000013 is emitted and err=0.
